display_scan_mux: RTL and testbench

Time-multiplexed driver for a multi-digit common-anode 7-segment display. Sits directly upstream of the 4-bit hex-to-7-segment decoder.
- Accepts a packed hex value through a valid/ready handshake.
- Double-buffers the value so display updates only occur at frame boundaries.
- Scans one digit at a time: presents that digit's nibble to the decoder and drives active-low digit enables.
- Inserts a dead-time gap between digits (anti-ghosting) and optionally suppresses leading zeros.

---
 rtl/disp_pkg.sv | 22 ++
 rtl/display_scan_mux_lz.sv | 22 ++
 rtl/display_scan_mux.sv | 126 ++++++++++++
 tb/tb_display_scan_mux.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and sizing helpers for the multiplexed 7-segment scan driver.
package disp_pkg;

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } state_t;

  // Widest digit count supported; narrower displays take the low bits.
  localparam logic [7:0] ALL_OFF = 8'hFF;

  function automatic int cnt_width(input int clk_div, input int blank_cycles);
    int m;
    m = (clk_div > blank_cycles) ? clk_div : blank_cycles;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

  function automatic int idx_width(input int num_digits);
    return ($clog2(num_digits) < 1) ? 1 : $clog2(num_digits);
  endfunction

endpackage

// File: rtl/display_scan_mux_lz.sv
// Leading-zero suppression mask: bit k set when digit k and everything above it are zero.
module lz_suppress_mask #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] display_reg,
  input  logic                    lz_blank_en,
  output logic [NUM_DIGITS-1:0]   mask
);

  logic upper_zero;

  // Digit 0 is left out of the walk so a zero value still shows one "0".
  always_comb begin
    mask       = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (display_reg[4*k +: 4] == 4'h0);
      mask[k]    = lz_blank_en & upper_zero;
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with a double-buffered value,
// per-digit dead time and optional leading-zero blanking.
module display_scan_mux
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic                    lz_blank_en,
  output logic [3:0]              nibble_out,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_start
);

  localparam int CW = cnt_width(CLK_DIV, BLANK_CYCLES);
  localparam int IW = idx_width(NUM_DIGITS);
  localparam logic [CW-1:0]         SHOW_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]         GAP_LAST  = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] OFF_N     = ALL_OFF[NUM_DIGITS-1:0];

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("display_scan_mux: NUM_DIGITS must be in 1..8");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("display_scan_mux: CLK_DIV must be at least 2");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("display_scan_mux: BLANK_CYCLES must be at least 1");
  end

  logic [4*NUM_DIGITS-1:0] display_reg;
  logic [4*NUM_DIGITS-1:0] pending_reg;
  logic                    pending_full;
  logic [IW-1:0]           digit_idx;
  state_t                  state;
  logic [CW-1:0]           counter;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              cur_nibble;
  logic [NUM_DIGITS-1:0]   next_en_n;

  // Handshake: a value moves into pending_reg on any edge where value_valid
  // and value_ready are both high; value_ready is simply "pending slot empty".
  assign value_ready = ~pending_full;

  lz_suppress_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz (
    .display_reg(display_reg),
    .lz_blank_en(lz_blank_en),
    .mask       (lz_mask)
  );

  always_comb begin
    cur_nibble = 4'h0;
    next_en_n  = OFF_N;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IW'(k)) begin
        cur_nibble   = display_reg[4*k +: 4];
        next_en_n[k] = lz_mask[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_reg  <= '0;
      pending_reg  <= '0;
      pending_full <= 1'b0;
      digit_idx    <= '0;
      state        <= GAP;
      counter      <= '0;
      nibble_out   <= 4'h0;
      digit_en_n   <= OFF_N;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= 1'b0;

      if (value_valid && !pending_full) begin
        pending_reg  <= value_in;
        pending_full <= 1'b1;
      end

      case (state)
        SHOW: begin
          if (counter == SHOW_LAST) begin
            digit_en_n <= OFF_N;
            counter    <= '0;
            state      <= GAP;
            if (digit_idx == IDX_LAST) begin
              digit_idx <= '0;
              // Frame boundary: the only point a new value may reach the display.
              if (pending_full) begin
                display_reg  <= pending_reg;
                pending_full <= 1'b0;
              end
            end else begin
              digit_idx <= digit_idx + 1'b1;
            end
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          if (counter == GAP_LAST) begin
            // Nibble and enable change together while every digit is dark.
            nibble_out  <= cur_nibble;
            digit_en_n  <= next_en_n;
            frame_start <= (digit_idx == '0);
            counter     <= '0;
            state       <= SHOW;
          end else begin
            counter <= counter + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with NUM_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=2.
module tb_display_scan_mux;

  logic        clk;
  logic        rst_n;
  logic [15:0] value_in;
  logic        value_valid;
  logic        value_ready;
  logic        lz_blank_en;
  logic [3:0]  nibble_out;
  logic [3:0]  digit_en_n;
  logic        frame_start;

  int tests;
  int fails;

  display_scan_mux #(
    .NUM_DIGITS  (4),
    .CLK_DIV     (4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .lz_blank_en(lz_blank_en),
    .nibble_out (nibble_out),
    .digit_en_n (digit_en_n),
    .frame_start(frame_start)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [15:0] v);
    value_in    = v;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
  endtask

  task automatic wait_frame_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_frame(input bit ok, input string name);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: frame_start not seen within 100 cycles", name);
    end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({digit_en_n, nibble_out, frame_start, value_ready} !== {4'b1111, 4'h0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_values: en=%b nib=%h fs=%b rdy=%b, want en=1111 nib=0 fs=0 rdy=1",
               digit_en_n, nibble_out, frame_start, value_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tests++;
    if (digit_en_n !== 4'b1111) begin
      fails++; $display("FAIL first_gap: en=%b want 1111", digit_en_n);
    end
    tick();
    tests++;
    if ({digit_en_n, nibble_out, frame_start} !== {4'b1110, 4'h0, 1'b1}) begin
      fails++;
      $display("FAIL first_enable: en=%b nib=%h fs=%b want 1110 0 1", digit_en_n, nibble_out, frame_start);
    end
    tick();
    tests++;
    if (frame_start !== 1'b0) begin
      fails++; $display("FAIL fs_pulse_width: fs=%b want 0", frame_start);
    end
    tick_n(2);
    tests++;
    if (digit_en_n !== 4'b1110) begin
      fails++; $display("FAIL enable_hold: en=%b want 1110", digit_en_n);
    end
    tick();
    tests++;
    if (digit_en_n !== 4'b1111) begin
      fails++; $display("FAIL dead_time_1: en=%b want 1111", digit_en_n);
    end
    tick();
    tests++;
    if (digit_en_n !== 4'b1111) begin
      fails++; $display("FAIL dead_time_2: en=%b want 1111", digit_en_n);
    end
    tick();
    tests++;
    if (digit_en_n !== 4'b1101) begin
      fails++; $display("FAIL second_digit: en=%b want 1101", digit_en_n);
    end
  endtask

  task automatic test_scan_value();
    bit ok;
    logic [3:0] exp_en[4];
    logic [3:0] exp_nib[4];
    exp_en  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_nib = '{4'hF, 4'h3, 4'hA, 4'h1};
    send(16'h1A3F);
    tests++;
    if (value_ready !== 1'b0) begin
      fails++; $display("FAIL accept_1a3f: rdy=%b want 0", value_ready);
    end
    wait_frame_start(ok);
    chk_frame(ok, "scan_frame");
    tests++;
    if (value_ready !== 1'b1) begin
      fails++; $display("FAIL ready_after_wrap: rdy=%b want 1", value_ready);
    end
    for (int d = 0; d < 4; d++) begin
      tests++;
      if ({digit_en_n, nibble_out} !== {exp_en[d], exp_nib[d]}) begin
        fails++;
        $display("FAIL scan_digit%0d: en=%b nib=%h want %b %h", d, digit_en_n, nibble_out, exp_en[d], exp_nib[d]);
      end
      tick_n(4);
      tests++;
      if (digit_en_n !== 4'b1111) begin
        fails++; $display("FAIL scan_gap%0d: en=%b want 1111", d, digit_en_n);
      end
      tick_n(2);
    end
    tests++;
    if ({frame_start, digit_en_n} !== {1'b1, 4'b1110}) begin
      fails++; $display("FAIL frame_period: fs=%b en=%b want 1 1110", frame_start, digit_en_n);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int cnt;
    send(16'h1111);
    tests++;
    if (value_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_first_accept: rdy=%b want 0", value_ready);
    end
    value_in    = 16'h2222;
    value_valid = 1'b1;
    cnt = 0;
    while (value_ready !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    tests++;
    if (cnt != 21) begin
      fails++; $display("FAIL b2b_ready_low_cycles: got %0d want 21", cnt);
    end
    tick();
    value_valid = 1'b0;
    tests++;
    if (value_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_second_accept: rdy=%b want 0", value_ready);
    end
    wait_frame_start(ok);
    chk_frame(ok, "b2b_frame1");
    tests++;
    if ({digit_en_n, nibble_out} !== {4'b1110, 4'h1}) begin
      fails++; $display("FAIL b2b_show_1111_d0: en=%b nib=%h want 1110 1", digit_en_n, nibble_out);
    end
    tick_n(18);
    tests++;
    if ({digit_en_n, nibble_out} !== {4'b0111, 4'h1}) begin
      fails++; $display("FAIL b2b_show_1111_d3: en=%b nib=%h want 0111 1", digit_en_n, nibble_out);
    end
    wait_frame_start(ok);
    chk_frame(ok, "b2b_frame2");
    tests++;
    if ({digit_en_n, nibble_out} !== {4'b1110, 4'h2}) begin
      fails++; $display("FAIL b2b_show_2222: en=%b nib=%h want 1110 2", digit_en_n, nibble_out);
    end
  endtask

  task automatic test_lz_blank();
    bit ok;
    logic [3:0] exp_en[4];
    logic [3:0] exp_nib[4];
    lz_blank_en = 1'b1;
    send(16'h0050);
    wait_frame_start(ok);
    chk_frame(ok, "lz_0050_frame");
    exp_en  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    exp_nib = '{4'h0, 4'h5, 4'h0, 4'h0};
    for (int d = 0; d < 4; d++) begin
      tests++;
      if ({digit_en_n, nibble_out} !== {exp_en[d], exp_nib[d]}) begin
        fails++;
        $display("FAIL lz_0050_d%0d: en=%b nib=%h want %b %h", d, digit_en_n, nibble_out, exp_en[d], exp_nib[d]);
      end
      if (d < 3) tick_n(6);
    end
    wait_frame_start(ok);
    chk_frame(ok, "lz_0000_send");
    send(16'h0000);
    wait_frame_start(ok);
    chk_frame(ok, "lz_0000_frame");
    exp_en = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    for (int d = 0; d < 4; d++) begin
      tests++;
      if ({digit_en_n, nibble_out} !== {exp_en[d], 4'h0}) begin
        fails++;
        $display("FAIL lz_0000_d%0d: en=%b nib=%h want %b 0", d, digit_en_n, nibble_out, exp_en[d]);
      end
      if (d < 3) tick_n(6);
    end
  endtask

  task automatic test_lz_toggle();
    bit ok;
    wait_frame_start(ok);
    chk_frame(ok, "toggle_frame");
    tick();
    lz_blank_en = 1'b0;
    tick_n(2);
    tests++;
    if (digit_en_n !== 4'b1110) begin
      fails++; $display("FAIL toggle_no_glitch_d0: en=%b want 1110", digit_en_n);
    end
    tick_n(3);
    tests++;
    if ({digit_en_n, nibble_out} !== {4'b1101, 4'h0}) begin
      fails++; $display("FAIL toggle_d1_shown: en=%b nib=%h want 1101 0", digit_en_n, nibble_out);
    end
    tick();
    lz_blank_en = 1'b1;
    tick();
    tests++;
    if (digit_en_n !== 4'b1101) begin
      fails++; $display("FAIL toggle_no_glitch_d1: en=%b want 1101", digit_en_n);
    end
    tick_n(4);
    tests++;
    if (digit_en_n !== 4'b1111) begin
      fails++; $display("FAIL toggle_d2_blanked: en=%b want 1111", digit_en_n);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    lz_blank_en = 1'b0;
    wait_frame_start(ok);
    chk_frame(ok, "arst_frame");
    send(16'hBEEF);
    tests++;
    if ({value_ready, digit_en_n} !== {1'b0, 4'b1110}) begin
      fails++; $display("FAIL arst_setup: rdy=%b en=%b want 0 1110", value_ready, digit_en_n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({digit_en_n, value_ready, nibble_out} !== {4'b1111, 1'b1, 4'h0}) begin
      fails++;
      $display("FAIL arst_immediate: en=%b rdy=%b nib=%h want 1111 1 0", digit_en_n, value_ready, nibble_out);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_frame_start(ok);
    chk_frame(ok, "arst_after");
    tests++;
    if ({digit_en_n, nibble_out} !== {4'b1110, 4'h0}) begin
      fails++; $display("FAIL arst_d0: en=%b nib=%h want 1110 0", digit_en_n, nibble_out);
    end
    tick_n(6);
    tests++;
    if ({digit_en_n, nibble_out} !== {4'b1101, 4'h0}) begin
      fails++; $display("FAIL arst_d1: en=%b nib=%h want 1101 0", digit_en_n, nibble_out);
    end
    tick_n(12);
    tests++;
    if ({digit_en_n, nibble_out} !== {4'b0111, 4'h0}) begin
      fails++; $display("FAIL arst_d3: en=%b nib=%h want 0111 0", digit_en_n, nibble_out);
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst_n       = 1'b0;
    value_in    = '0;
    value_valid = 1'b0;
    lz_blank_en = 1'b0;
    test_reset();
    test_scan_value();
    test_back_to_back();
    test_lz_blank();
    test_lz_toggle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
